fp_mul_iter: RTL
================

FP_MUL_ITER -- requirements
Module: fp_mul_iter

Interface
REQ-001 SHALL have parameter EXP_W, default 8, exponent field width (5 = half, 8 = single).
REQ-002 SHALL have parameter MANT_W, default 23, stored fraction width (10 = half, 23 = single); word width W = 1+EXP_W+MANT_W.
REQ-003 SHALL have ports: clk in 1, the single clock; rst in 1, synchronous active-high reset.
REQ-004 SHALL have ports: start in 1, request strobe; op_a in W, multiplicand; op_b in W, multiplier; round_mode in 2, 00=nearest-even, 01=toward-zero, 10=up, 11=down.
REQ-005 SHALL have ports: busy out 1, operation in flight; valid_out out 1, one-cycle result strobe; result out W, IEEE-754 product; flags out 5, {invalid, div_by_zero, overflow, underflow, inexact}.

Function
REQ-006 SHALL use states IDLE, UNPACK, MUL, ROUND, DONE; IDLE->UNPACK on start; UNPACK->DONE for special operands, else ->MUL; MUL->ROUND after MANT_W+1 cycles; ROUND->DONE; DONE->IDLE unconditionally.
REQ-007 SHALL capture op_a, op_b and round_mode only on a start edge in IDLE; start in any other state is ignored and has no effect.
REQ-008 SHALL hold busy high in every state except IDLE.
REQ-009 SHALL assert valid_out for exactly one cycle in DONE: MANT_W+4 cycles after the accepting edge for finite nonzero operands; 2 cycles for special operands.
REQ-010 SHALL hold result and flags stable from valid_out until the next valid_out.
REQ-011 SHALL form significand product with shift-add, one multiplier bit per MUL cycle, into a 2*(MANT_W+1)-bit accumulator.
REQ-012 SHALL compute sign as XOR of operand signs for all results, including zero and infinity.
REQ-013 SHALL flush subnormal inputs to signed zero before multiplication.
REQ-014 SHALL normalise by at most one left shift, then round with guard and sticky bits per round_mode, renormalising on mantissa carry-out.
REQ-015 SHALL, on overflow, return infinity for nearest-even and for the direction matching the sign; else max finite; overflow=inexact=1.
REQ-016 SHALL, when the rounded exponent is below 1, return signed zero with underflow=inexact=1.
REQ-017 SHALL return canonical qNaN (sign 0, exponent all ones, fraction MSB 1, remainder 0) for any NaN operand or 0*Inf.
REQ-018 SHALL set invalid for 0*Inf or a signalling-NaN operand (fraction MSB 0); qNaN propagation sets no flag.
REQ-019 SHALL return signed infinity for Inf*finite-nonzero and signed zero for zero*finite, flags 0.
REQ-020 SHALL hold div_by_zero at 0.

Reset
REQ-021 SHALL on rst force state IDLE, busy 0, valid_out 0, result 0, flags 0, aborting any operation; no valid_out for the aborted operation.
REQ-022 SHALL accept start on the first cycle after rst deasserts.

Configuration
REQ-023 SHALL support macro FP_STICKY_FLAGS_EN: when defined, add input flags_clr (1 bit) and flags ORs each new result's flags into itself; flags_clr zeroes flags next cycle, and a simultaneous valid_out loads only the new flags.
REQ-024 SHALL, without FP_STICKY_FLAGS_EN, have no flags_clr port and load flags per-operation at valid_out.

Structure
REQ-025 SHALL place round-mode encodings, flag bit indices and state encodings in shared package fp_pkg.
REQ-026 SHALL implement normalise/round/overflow/underflow in combinational sub-module fp_rounder, parametrised by EXP_W and MANT_W.

Verification
REQ-027 SHALL cover: default params, 0x3FC00000*0x40000000, RNE -> result 0x40400000, flags 0, valid_out 27 cycles after accept.
REQ-028 SHALL cover: 0x3F800001*0x3F800001 -> RNE 0x3F800002 inexact; RTZ 0x3F800002 inexact; up 0x3F800003 inexact.
REQ-029 SHALL cover: 0x7F000000*0x40000000 -> RNE 0x7F800000 flags 00101; RTZ 0x7F7FFFFF flags 00101.
REQ-030 SHALL cover: 0x00000000*0x7F800000 -> 0x7FC00000, flags 10000, valid_out 2 cycles after accept; 0xFF800000*0x40000000 -> 0xFF800000, flags 0.
REQ-031 SHALL cover: EXP_W=5, MANT_W=10, 0x3C00*0xBC00 -> 0xBC00, flags 0, latency 14; start during busy ignored.
REQ-032 SHALL cover: rst asserted mid-MUL -> outputs zeroed, no valid_out, next start completes normally.

Source files
------------

// File: rtl/fp_pkg.sv
// fp_pkg: shared round-mode, flag-index and FSM state encodings for the iterative FP multiplier.
package fp_pkg;
  localparam logic [1:0] RM_RNE = 2'b00;
  localparam logic [1:0] RM_RTZ = 2'b01;
  localparam logic [1:0] RM_UP = 2'b10;
  localparam logic [1:0] RM_DN = 2'b11;
  localparam int FLAG_INV = 4;
  localparam int FLAG_DZ = 3;
  localparam int FLAG_OF = 2;
  localparam int FLAG_UF = 1;
  localparam int FLAG_NX = 0;
  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_UNPACK = 3'd1;
  localparam logic [2:0] S_MUL = 3'd2;
  localparam logic [2:0] S_ROUND = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;
endpackage

// File: rtl/fp_rounder.sv
// fp_rounder: combinational normalise, round, overflow and underflow of a raw significand product.
module fp_rounder
  import fp_pkg::*;
#(
  parameter int EXP_W = 8,
  parameter int MANT_W = 23
) (
  input  logic sign,
  input  logic signed [EXP_W+1:0] exp_in,
  input  logic [2*MANT_W+1:0] prod,
  input  logic [1:0] round_mode,
  output logic [EXP_W+MANT_W:0] result,
  output logic [4:0] flags
);
  localparam int N = MANT_W + 1;
  localparam logic signed [EXP_W+1:0] EMAX = (EXP_W+2)'((1 << EXP_W) - 1);
  localparam logic signed [EXP_W+1:0] ONE = (EXP_W+2)'(1);
  logic top, guard, sticky, inc, ovf, unf, to_inf;
  logic [MANT_W-1:0] frac;
  logic [MANT_W:0] frac_r;
  logic signed [EXP_W+1:0] exp_n, exp_r;
  always_comb begin
    top = prod[2*N-1];
    frac = top ? prod[2*N-2:N] : prod[2*N-3:N-1];
    guard = top ? prod[N-1] : prod[N-2];
    sticky = top ? |prod[N-2:0] : |prod[N-3:0];
    exp_n = exp_in + $signed({{(EXP_W+1){1'b0}}, top});
    inc = round_mode == RM_RNE ? guard & (sticky | frac[0]) :
          round_mode == RM_RTZ ? 1'b0 :
          round_mode == RM_UP ? ~sign & (guard | sticky) : sign & (guard | sticky);
    frac_r = {1'b0, frac} + {{MANT_W{1'b0}}, inc};
    // a carry out leaves the fraction at zero, so only the exponent moves
    exp_r = exp_n + $signed({{(EXP_W+1){1'b0}}, frac_r[MANT_W]});
    ovf = exp_r >= EMAX;
    unf = exp_r < ONE;
    to_inf = round_mode == RM_RNE | (round_mode == RM_UP & ~sign) | (round_mode == RM_DN & sign);
    result = ovf ? (to_inf ? {sign, {EXP_W{1'b1}}, {MANT_W{1'b0}}} : {sign, {(EXP_W-1){1'b1}}, 1'b0, {MANT_W{1'b1}}}) :
             unf ? {sign, {(EXP_W+MANT_W){1'b0}}} :
             {sign, exp_r[EXP_W-1:0], frac_r[MANT_W-1:0]};
    flags = '0;
    flags[FLAG_OF] = ovf;
    flags[FLAG_UF] = unf;
    flags[FLAG_NX] = ovf | unf | guard | sticky;
  end
endmodule

// File: rtl/fp_mul_iter.sv
// fp_mul_iter: iterative shift-add IEEE-754 multiplier, one multiplier bit per cycle.
// Optional FP_STICKY_FLAGS_EN adds flags_clr and accumulates flags across operations.
module fp_mul_iter
  import fp_pkg::*;
#(
  parameter int EXP_W = 8,
  parameter int MANT_W = 23
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic [EXP_W+MANT_W:0] op_a,
  input  logic [EXP_W+MANT_W:0] op_b,
  input  logic [1:0] round_mode,
`ifdef FP_STICKY_FLAGS_EN
  input  logic flags_clr,
`endif
  output logic busy,
  output logic valid_out,
  output logic [EXP_W+MANT_W:0] result,
  output logic [4:0] flags
);
  localparam int W = 1 + EXP_W + MANT_W;
  localparam int N = MANT_W + 1;
  localparam int CW = $clog2(N);
  localparam logic [CW-1:0] LAST = CW'(MANT_W);
  localparam logic signed [EXP_W+1:0] BIAS = (EXP_W+2)'((1 << (EXP_W - 1)) - 1);
  logic [2:0] state, state_d;
  logic [W-1:0] a_q, b_q, sp_res, new_res, r_res;
  logic [1:0] rm_q;
  logic sign_q;
  logic signed [EXP_W+1:0] exp_q, exp_p;
  logic [MANT_W:0] mcand, mplier;
  logic [2*N-1:0] acc;
  logic [N:0] sum;
  logic [CW-1:0] cnt;
  logic [EXP_W-1:0] ea, eb;
  logic [MANT_W-1:0] fa, fb;
  logic a_max, b_max, a_zero, b_zero, a_nan, b_nan, a_inf, b_inf, a_snan, b_snan;
  logic sign_p, zi, special, ld;
  logic [4:0] sp_flags, new_flags, r_flags;
  assign ea = a_q[W-2:MANT_W];
  assign eb = b_q[W-2:MANT_W];
  assign fa = a_q[MANT_W-1:0];
  assign fb = b_q[MANT_W-1:0];
  assign a_max = &ea;
  assign b_max = &eb;
  // a zero exponent field covers subnormals, which are flushed to zero
  assign a_zero = ~|ea;
  assign b_zero = ~|eb;
  assign a_nan = a_max & |fa;
  assign b_nan = b_max & |fb;
  assign a_inf = a_max & ~|fa;
  assign b_inf = b_max & ~|fb;
  assign a_snan = a_nan & ~fa[MANT_W-1];
  assign b_snan = b_nan & ~fb[MANT_W-1];
  assign sign_p = a_q[W-1] ^ b_q[W-1];
  assign zi = (a_zero & b_inf) | (b_zero & a_inf);
  assign special = a_max | b_max | a_zero | b_zero;
  assign exp_p = $signed({2'b00, ea}) + $signed({2'b00, eb}) - BIAS;
  assign sp_res = (a_nan | b_nan | zi) ? {1'b0, {EXP_W{1'b1}}, 1'b1, {(MANT_W-1){1'b0}}} :
                  (a_inf | b_inf) ? {sign_p, {EXP_W{1'b1}}, {MANT_W{1'b0}}} : {sign_p, {(W-1){1'b0}}};
  assign sum = {1'b0, acc[2*N-1:N]} + (mplier[0] ? {1'b0, mcand} : '0);
  always_comb begin
    sp_flags = '0;
    sp_flags[FLAG_INV] = a_snan | b_snan | zi;
    state_d = state == S_IDLE ? (start ? S_UNPACK : S_IDLE) :
              state == S_UNPACK ? (special ? S_DONE : S_MUL) :
              state == S_MUL ? (cnt == LAST ? S_ROUND : S_MUL) :
              state == S_ROUND ? S_DONE : S_IDLE;
    ld = (state == S_UNPACK & special) | state == S_ROUND;
    new_res = state == S_ROUND ? r_res : sp_res;
    new_flags = state == S_ROUND ? r_flags : sp_flags;
  end
  fp_rounder #(.EXP_W(EXP_W), .MANT_W(MANT_W)) u_rnd (
    .sign(sign_q),
    .exp_in(exp_q),
    .prod(acc),
    .round_mode(rm_q),
    .result(r_res),
    .flags(r_flags)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      result <= '0;
      flags <= '0;
    end else begin
      state <= state_d;
      if (ld) result <= new_res;
`ifdef FP_STICKY_FLAGS_EN
      flags <= flags_clr ? (ld ? new_flags : '0) : (ld ? flags | new_flags : flags);
`else
      if (ld) flags <= new_flags;
`endif
    end
  end
  always_ff @(posedge clk) begin
    if (state == S_IDLE && start) begin
      a_q <= op_a;
      b_q <= op_b;
      rm_q <= round_mode;
    end
    if (state == S_UNPACK) begin
      sign_q <= sign_p;
      exp_q <= exp_p;
      mcand <= {1'b1, fa};
      mplier <= {1'b1, fb};
      acc <= '0;
      cnt <= '0;
    end
    if (state == S_MUL) begin
      acc <= {sum, acc[N-1:1]};
      mplier <= mplier >> 1;
      cnt <= cnt + 1'b1;
    end
  end
  assign busy = state != S_IDLE;
  assign valid_out = state == S_DONE;
endmodule
